// File: rtl/load_store_unit_pkg.sv
// Shared state encoding, width/exception codes and small helpers for the
// load/store unit and its load-extension datapath.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] MEM_BYTE  = 3'b000;
    localparam logic [2:0] MEM_HALF  = 3'b001;
    localparam logic [2:0] MEM_WORD  = 3'b010;
    localparam logic [2:0] MEM_DWORD = 3'b011;

    localparam logic [1:0] LSU_EXC_NONE       = 2'b00;
    localparam logic [1:0] LSU_EXC_MISALIGNED = 2'b01;
    localparam logic [1:0] LSU_EXC_RANGE      = 2'b10;
    localparam logic [1:0] LSU_EXC_ILLEGAL    = 2'b11;

    // The only load funct3 without a defined access (no "LDU" in RV64).
    localparam logic [2:0] F3_LOAD_ILLEGAL = 3'b111;

    function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load-result extension: narrows raw memory data to the access
// width and sign- or zero-extends it according to funct3.
module lsu_load_extend
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] raw,
    output logic [DATA_WIDTH-1:0] data
);

    logic is_signed;
    assign is_signed = ~funct3[2];

    always_comb begin
        data = raw;
        unique case ({1'b0, funct3[1:0]})
            MEM_BYTE:  data = {{(DATA_WIDTH-8){raw[7] & is_signed}}, raw[7:0]};
            MEM_HALF:  data = {{(DATA_WIDTH-16){raw[15] & is_signed}}, raw[15:0]};
            MEM_WORD:  data = {{(DATA_WIDTH-32){raw[31] & is_signed}}, raw[31:0]};
            MEM_DWORD: data = raw;
            default:   data = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from execute, checks it,
// drives the data-memory port for MEM_LATENCY cycles and returns one response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_base,
    input  logic [DATA_WIDTH-1:0] req_offset,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [4:0]            req_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [2:0]            mem_width,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_is_store,
    output logic [1:0]            resp_exc,
    output logic [DATA_WIDTH-1:0] resp_addr,
    output logic                  busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the initiator holds its payload stable while valid is high and not ready.

    localparam int EW    = DATA_WIDTH + 1;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(MEM_LATENCY - 1);
    localparam logic [EW-1:0]    MEM_BYTES = EW'(1) << ADDR_WIDTH;

    lsu_state_e state, state_next;
    logic [CNT_W-1:0] cnt;

    logic                  r_is_store;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_ea;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [4:0]            r_rd;

    logic [DATA_WIDTH-1:0] ea;
    logic [3:0]            size;
    logic [EW-1:0]         ea_end;
    logic [1:0]            exc;
    logic [DATA_WIDTH-1:0] ext_data;

    assign ea     = req_base + req_offset;
    assign size   = access_bytes(req_funct3);
    assign ea_end = {1'b0, ea} + EW'(size);

    // The end address is checked one bit wider so addresses near 2**64 cannot wrap into range.
    always_comb begin
        exc = LSU_EXC_NONE;
        if (req_is_store ? req_funct3[2] : (req_funct3 == F3_LOAD_ILLEGAL))
            exc = LSU_EXC_ILLEGAL;
        else if ((ea[2:0] & (size[2:0] - 3'd1)) != 3'd0)
            exc = LSU_EXC_MISALIGNED;
        else if (ea_end > MEM_BYTES)
            exc = LSU_EXC_RANGE;
    end

    lsu_load_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_extend (
        .funct3(r_funct3),
        .raw   (mem_rdata),
        .data  (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            r_is_store <= 1'b0;
            r_funct3   <= '0;
            r_ea       <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            resp_data  <= '0;
            resp_exc   <= LSU_EXC_NONE;
        end else begin
            state <= state_next;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_is_store <= req_is_store;
                        r_funct3   <= req_funct3;
                        r_ea       <= ea;
                        r_wdata    <= req_wdata;
                        r_rd       <= req_rd;
                        resp_exc   <= exc;
                        resp_data  <= '0;
                        cnt        <= CNT_INIT;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        if (!r_is_store)
                            resp_data <= ext_data;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory strobes decode from state alone, so an async reset drops them at once.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_width  = '0;
        mem_wdata  = '0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid)
                    state_next = (exc == LSU_EXC_NONE) ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
                mem_addr  = r_ea[ADDR_WIDTH-1:0];
                mem_width = {1'b0, r_funct3[1:0]};
                if (r_is_store) begin
                    mem_we    = (cnt == CNT_INIT);
                    mem_wdata = r_wdata;
                end else begin
                    mem_re = 1'b1;
                end
                if (cnt == '0)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign resp_rd       = r_rd;
    assign resp_is_store = r_is_store;
    assign resp_addr     = r_ea;

endmodule
